// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, one bit per clock.
// A one-word holding register lets words stream with no idle cycles.
module serializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ready_o,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = MOD_WIDTH + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pend_len_q, pend_len_d;
  logic            pend_vld_q, pend_vld_d;
  logic            sdata_q, sdata_d;
  logic            sval_q, sval_d;
  logic [CW-1:0]   in_len;
  logic            accept;
  logic            last;

  assign in_len  = (data_mod_i == '0) ? CW'(W) : CW'(data_mod_i);
  assign ready_o = !pend_vld_q && !srst_i;
  assign accept  = data_val_i && ready_o;
  // cnt_q counts bits left including the one currently on the output
  assign last    = (state_q == SHIFT) && (cnt_q == CW'(1));

  assign ser_data_o     = sdata_q;
  assign ser_data_val_o = sval_q;
  assign busy_o         = (state_q == SHIFT) || pend_vld_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    pend_vld_d = pend_vld_q;
    sdata_d    = 1'b0;
    sval_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sval_d  = 1'b1;
          sdata_d = data_i[W-1];
          shift_d = {data_i[W-2:0], 1'b0};
          cnt_d   = in_len;
        end
      end
      SHIFT: begin
        if (!last) begin
          sval_d  = 1'b1;
          sdata_d = shift_q[W-1];
          shift_d = {shift_q[W-2:0], 1'b0};
          cnt_d   = cnt_q - CW'(1);
          if (accept) begin
            pend_d     = data_i;
            pend_len_d = in_len;
            pend_vld_d = 1'b1;
          end
        end else if (pend_vld_q) begin
          sval_d     = 1'b1;
          sdata_d    = pend_q[W-1];
          shift_d    = {pend_q[W-2:0], 1'b0};
          cnt_d      = pend_len_q;
          pend_vld_d = 1'b0;
        end else if (accept) begin
          sval_d  = 1'b1;
          sdata_d = data_i[W-1];
          shift_d = {data_i[W-2:0], 1'b0};
          cnt_d   = in_len;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_len_q <= '0;
      pend_vld_q <= 1'b0;
      sdata_q    <= 1'b0;
      sval_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      pend_vld_q <= pend_vld_d;
      sdata_q    <= sdata_d;
      sval_q     <= sval_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: reset, full/partial words,
// streaming, pending-full ordering, direct reload, mid-word reset.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ready_o;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int zero_viol = 0;
  bit cap[$];
  int cyc_q[$];
  bit expq[$];

  serializer #(.DATA_BUS_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ready_o        (ready_o),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    cyc++;
    if (ser_data_val_o) begin
      cap.push_back(ser_data_o);
      cyc_q.push_back(cyc);
    end else if (ser_data_o) begin
      zero_viol++;
    end
  end

  function automatic void clear_all();
    cap.delete();
    cyc_q.delete();
    expq.delete();
  endfunction

  function automatic void add_exp(input logic [15:0] w, input int len);
    for (int i = 15; i >= 16 - len; i--) expq.push_back(w[i]);
  endfunction

  function automatic int diff_bits();
    int d;
    d = (cap.size() > expq.size()) ? cap.size() - expq.size()
                                   : expq.size() - cap.size();
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] != expq[i]) d++;
    return d;
  endfunction

  function automatic int gaps();
    int g = 0;
    for (int i = 1; i < cyc_q.size(); i++)
      if (cyc_q[i] != cyc_q[i-1] + 1) g++;
    return g;
  endfunction

  task automatic send(input logic [15:0] d, input logic [3:0] m,
                      output int waited);
    waited = 0;
    data_i = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    while (!ready_o && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    total++;
    if (waited >= 100) begin
      bad++;
      $display("FAIL send_timeout: ready_o=%0b required 1", ready_o);
    end
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || ser_data_val_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL idle_timeout: busy_o=%0b required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    #1 srst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total += 4;
    if (ser_data_o !== 1'b0) begin
      bad++; $display("FAIL rst_data: got %0b want 0", ser_data_o);
    end
    if (ser_data_val_o !== 1'b0) begin
      bad++; $display("FAIL rst_val: got %0b want 0", ser_data_val_o);
    end
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL rst_busy: got %0b want 0", busy_o);
    end
    if (ready_o !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got %0b want 0", ready_o);
    end
    srst_i = 1'b0;
    #1;
    total += 2;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL post_rst_ready: got %0b want 1", ready_o);
    end
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL post_rst_busy: got %0b want 0", busy_o);
    end
  endtask

  task automatic test_full();
    int w;
    @(negedge clk_i);
    clear_all();
    add_exp(16'hA5C3, 16);
    send(16'hA5C3, 4'd0, w);
    wait_idle();
    total += 3;
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL full_bits: got %0d bits, %0d diffs, want 16 exact",
                      cap.size(), diff_bits());
    end
    if (gaps() !== 0) begin
      bad++; $display("FAIL full_gap: got %0d gaps want 0", gaps());
    end
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL full_busy: got %0b want 0", busy_o);
    end
  endtask

  task automatic test_partial();
    int w;
    @(negedge clk_i);
    clear_all();
    expq = '{1'b1, 1'b1, 1'b1};
    send(16'hF000, 4'd3, w);
    wait_idle();
    total += 2;
    if (cap.size() !== 3) begin
      bad++; $display("FAIL partial_len: got %0d want 3", cap.size());
    end
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL partial_bits: got %0d diffs want 0", diff_bits());
    end
  endtask

  task automatic test_stream();
    int w;
    logic rdy_after_b;
    @(negedge clk_i);
    clear_all();
    add_exp(16'hFFFF, 16);
    add_exp(16'h0000, 16);
    add_exp(16'h8000, 1);
    send(16'hFFFF, 4'd0, w);
    send(16'h0000, 4'd0, w);
    rdy_after_b = ready_o;
    send(16'h8000, 4'd1, w);
    wait_idle();
    total += 5;
    if (rdy_after_b !== 1'b0) begin
      bad++; $display("FAIL stream_ready_low: got %0b want 0", rdy_after_b);
    end
    if (w == 0) begin
      bad++; $display("FAIL stream_wait: waited %0d cycles want >0", w);
    end
    if (cap.size() !== 33) begin
      bad++; $display("FAIL stream_len: got %0d want 33", cap.size());
    end
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL stream_bits: got %0d diffs want 0", diff_bits());
    end
    if (gaps() !== 0) begin
      bad++; $display("FAIL stream_gap: got %0d gaps want 0", gaps());
    end
  endtask

  task automatic test_pending_full();
    int w;
    @(negedge clk_i);
    clear_all();
    expq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    send(16'hA5C3, 4'd4, w);
    send(16'h6000, 4'd3, w);
    send(16'hF000, 4'd2, w);
    wait_idle();
    total += 3;
    if (w == 0) begin
      bad++; $display("FAIL pend_wait: waited %0d cycles want >0", w);
    end
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL pend_order: got %0d bits %0d diffs want 9 exact",
                      cap.size(), diff_bits());
    end
    if (gaps() !== 0) begin
      bad++; $display("FAIL pend_gap: got %0d gaps want 0", gaps());
    end
  endtask

  task automatic test_direct();
    int w;
    @(negedge clk_i);
    clear_all();
    expq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    send(16'hC000, 4'd2, w);
    @(negedge clk_i);
    send(16'h4000, 4'd2, w);
    @(negedge clk_i);
    send(16'h8000, 4'd1, w);
    wait_idle();
    total += 2;
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL direct_bits: got %0d bits %0d diffs want 5 exact",
                      cap.size(), diff_bits());
    end
    if (gaps() !== 0) begin
      bad++; $display("FAIL direct_gap: got %0d gaps want 0", gaps());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int ones;
    @(negedge clk_i);
    clear_all();
    send(16'hFFFF, 4'd0, w);
    send(16'h1234, 4'd0, w);
    repeat (3) @(negedge clk_i);
    #1 srst_i = 1'b1;
    #1;
    ones = 0;
    foreach (cap[i]) if (cap[i]) ones++;
    total += 5;
    if (cap.size() !== 5 || ones !== 5) begin
      bad++; $display("FAIL mid_prefix: got %0d bits (%0d ones) want 5 ones",
                      cap.size(), ones);
    end
    if (ser_data_val_o !== 1'b0) begin
      bad++; $display("FAIL mid_val: got %0b want 0", ser_data_val_o);
    end
    if (ser_data_o !== 1'b0) begin
      bad++; $display("FAIL mid_data: got %0b want 0", ser_data_o);
    end
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL mid_busy: got %0b want 0", busy_o);
    end
    if (ready_o !== 1'b0) begin
      bad++; $display("FAIL mid_ready: got %0b want 0", ready_o);
    end
    @(negedge clk_i);
    srst_i = 1'b0;
    #1;
    total += 2;
    if (ready_o !== 1'b1) begin
      bad++; $display("FAIL mid_rel_ready: got %0b want 1", ready_o);
    end
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL mid_rel_busy: got %0b want 0", busy_o);
    end
    repeat (20) @(negedge clk_i);
    total++;
    if (cap.size() !== 5) begin
      bad++; $display("FAIL mid_dropped: got %0d bits want 5", cap.size());
    end
    clear_all();
    add_exp(16'h8001, 16);
    send(16'h8001, 4'd0, w);
    wait_idle();
    total += 2;
    if (diff_bits() !== 0) begin
      bad++; $display("FAIL mid_next: got %0d bits %0d diffs want 16 exact",
                      cap.size(), diff_bits());
    end
    if (gaps() !== 0) begin
      bad++; $display("FAIL mid_next_gap: got %0d gaps want 0", gaps());
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_stream();
    test_pending_full();
    test_direct();
    test_reset_mid();
    total++;
    if (zero_viol !== 0) begin
      bad++; $display("FAIL idle_zero: got %0d nonzero idle bits want 0",
                      zero_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
